lenet_load_ctrl: RTL and testbench

Sequencer between the AXI4-Lite slave register file and the LeNet inference core. Decodes completed register writes, steers the weight, bias and feature-map word streams into the core's buffers with auto-incrementing addresses, launches inference once every buffer is full, and latches the classification result and done status for readback. It also times each inference and flags protocol misuse.

---
 rtl/lenet_load_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_lenet_load_ctrl.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_load_ctrl.sv
// lenet_load_ctrl: decodes register writes, streams weights/biases/pixels
// into the LeNet core buffers, launches inference and latches its result.
module lenet_load_ctrl #(
    parameter int N_WEIGHT = 3220,
    parameter int N_BIAS   = 10,
    parameter int N_FMAP   = 784,
    parameter int DATA_W   = 32,
    parameter int RES_W    = 4
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,
    input  logic              reg_wr_valid,
    input  logic [4:0]        reg_wr_addr,
    input  logic [DATA_W-1:0] reg_wr_data,
    output logic              w_we,
    output logic [11:0]       w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              b_we,
    output logic [3:0]        b_addr,
    output logic [DATA_W-1:0] b_data,
    output logic              f_we,
    output logic [9:0]        f_addr,
    output logic [DATA_W-1:0] f_data,
    output logic              core_start,
    input  logic              core_done,
    input  logic [RES_W-1:0]  core_result,
    output logic              status_done,
    output logic [DATA_W-1:0] result_out,
    output logic [31:0]       perf_cycles,
    output logic              err_sticky
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [11:0] W_LAST = 12'(N_WEIGHT);
    localparam logic [3:0]  B_LAST = 4'(N_BIAS);
    localparam logic [9:0]  F_LAST = 10'(N_FMAP);

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [11:0] w_cnt;
    logic [3:0]  b_cnt;
    logic [9:0]  f_cnt;

    logic is_en;
    logic is_w;
    logic is_b;
    logic is_f;
    logic is_clr;
    logic is_strm;
    logic abort;
    logic go_idle;

    logic w_full;
    logic b_full;
    logic f_full;
    logic acc_w;
    logic acc_b;
    logic acc_f;
    logic w_fin;
    logic b_fin;
    logic f_fin;
    logic all_fin;
    logic strm_err;
    logic latch_res;

    always_comb begin
        is_en  = 1'b0;
        is_w   = 1'b0;
        is_b   = 1'b0;
        is_f   = 1'b0;
        is_clr = 1'b0;
        if (reg_wr_valid) begin
            case (reg_wr_addr)
                5'h00:   is_en  = 1'b1;
                5'h04:   is_w   = 1'b1;
                5'h08:   is_b   = 1'b1;
                5'h0C:   is_f   = 1'b1;
                5'h1C:   is_clr = reg_wr_data[0];
                default: ;
            endcase
        end
    end

    assign is_strm = is_w | is_b | is_f;
    assign abort   = is_en & ~reg_wr_data[0];
    assign go_idle = is_clr | abort;

    assign w_full = (w_cnt == W_LAST);
    assign b_full = (b_cnt == B_LAST);
    assign f_full = (f_cnt == F_LAST);

    assign acc_w = is_w & (state == S_LOAD) & ~w_full;
    assign acc_b = is_b & (state == S_LOAD) & ~b_full;
    assign acc_f = is_f & (state == S_LOAD) & ~f_full;

    // Completion is judged on the post-increment counts so START
    // coincides with the final buffer write.
    assign w_fin = w_full | (acc_w & (w_cnt + 12'd1 == W_LAST));
    assign b_fin = b_full | (acc_b & (b_cnt + 4'd1 == B_LAST));
    assign f_fin = f_full | (acc_f & (f_cnt + 10'd1 == F_LAST));
    assign all_fin = w_fin & b_fin & f_fin;

    assign strm_err  = is_strm & ~(acc_w | acc_b | acc_f);
    assign latch_res = (state == S_RUN) & core_done & ~go_idle;

    always_comb begin
        state_nx = state;
        if (go_idle) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (is_en) state_nx = S_LOAD;
                S_LOAD:  if (all_fin) state_nx = S_START;
                S_START: state_nx = S_RUN;
                S_RUN:   if (core_done) state_nx = S_DONE;
                S_DONE:  ;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_cnt <= '0;
            b_cnt <= '0;
            f_cnt <= '0;
        end else if (go_idle) begin
            w_cnt <= '0;
            b_cnt <= '0;
            f_cnt <= '0;
        end else begin
            if (acc_w) w_cnt <= w_cnt + 12'd1;
            if (acc_b) b_cnt <= b_cnt + 4'd1;
            if (acc_f) f_cnt <= f_cnt + 10'd1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_we   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            b_we   <= 1'b0;
            b_addr <= '0;
            b_data <= '0;
            f_we   <= 1'b0;
            f_addr <= '0;
            f_data <= '0;
        end else begin
            w_we <= acc_w;
            b_we <= acc_b;
            f_we <= acc_f;
            if (acc_w) begin
                w_addr <= w_cnt;
                w_data <= reg_wr_data;
            end
            if (acc_b) begin
                b_addr <= b_cnt;
                b_data <= reg_wr_data;
            end
            if (acc_f) begin
                f_addr <= f_cnt;
                f_data <= reg_wr_data;
            end
        end
    end

    // The core_start cycle itself is RUN but not counted.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            core_start  <= 1'b0;
            perf_cycles <= '0;
        end else begin
            core_start <= (state == S_START) & ~go_idle;
            if (is_clr) begin
                perf_cycles <= '0;
            end else if ((state == S_START) && !go_idle) begin
                perf_cycles <= '0;
            end else if ((state == S_RUN) && !go_idle && !core_start) begin
                if (perf_cycles != 32'hFFFF_FFFF) begin
                    perf_cycles <= perf_cycles + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            status_done <= 1'b0;
            result_out  <= '0;
            err_sticky  <= 1'b0;
        end else begin
            status_done <= (state_nx == S_DONE);
            if (is_clr) begin
                result_out <= '0;
                err_sticky <= 1'b0;
            end else begin
                if (latch_res) begin
                    result_out <= {{(DATA_W-RES_W){1'b0}}, core_result};
                end
                if (strm_err) err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lenet_load_ctrl.sv
// Bench for lenet_load_ctrl: table vectors, directed load/run sequences
// and a randomized soak, all checked against a queue-based model.
module tb_lenet_load_ctrl;

    localparam int NW = 3220;
    localparam int NB = 10;
    localparam int NF = 784;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_wr_valid = 1'b0;
    logic [4:0]  reg_wr_addr = '0;
    logic [31:0] reg_wr_data = '0;
    logic        core_done = 1'b0;
    logic [3:0]  core_result = '0;
    logic        w_we;
    logic [11:0] w_addr;
    logic [31:0] w_data;
    logic        b_we;
    logic [3:0]  b_addr;
    logic [31:0] b_data;
    logic        f_we;
    logic [9:0]  f_addr;
    logic [31:0] f_data;
    logic        core_start;
    logic        status_done;
    logic [31:0] result_out;
    logic [31:0] perf_cycles;
    logic        err_sticky;

    always #5 clk = ~clk;

    lenet_load_ctrl dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .reg_wr_valid(reg_wr_valid),
        .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data),
        .w_we(w_we),
        .w_addr(w_addr),
        .w_data(w_data),
        .b_we(b_we),
        .b_addr(b_addr),
        .b_data(b_data),
        .f_we(f_we),
        .f_addr(f_addr),
        .f_data(f_data),
        .core_start(core_start),
        .core_done(core_done),
        .core_result(core_result),
        .status_done(status_done),
        .result_out(result_out),
        .perf_cycles(perf_cycles),
        .err_sticky(err_sticky)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_starts = 0;
    int n_we = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          a;
        logic [31:0] d;
    } ent_t;

    ent_t qw[$];
    ent_t qb[$];
    ent_t qf[$];

    // model of the spec: counts, phase flags and expected port writes
    int          mw, mb, mf;
    bit          m_load, m_run, m_done, m_err;
    logic [31:0] m_res, m_perf;
    bit          m_perf_ok;
    int          m_starts = 0;
    int          m_start_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (core_start) n_starts++;
        if (w_we) begin
            n_we++;
            n_tests++;
            if (qw.size() == 0) begin
                n_fail++;
                $display("FAIL w_port: unexpected write addr %0d", w_addr);
            end else begin
                e = qw.pop_front();
                if (w_addr !== 12'(e.a) || w_data !== e.d) begin
                    n_fail++;
                    $display("FAIL w_port: got %0d/%h expected %0d/%h",
                             w_addr, w_data, e.a, e.d);
                end
            end
        end
        if (b_we) begin
            n_we++;
            n_tests++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL b_port: unexpected write addr %0d", b_addr);
            end else begin
                e = qb.pop_front();
                if (b_addr !== 4'(e.a) || b_data !== e.d) begin
                    n_fail++;
                    $display("FAIL b_port: got %0d/%h expected %0d/%h",
                             b_addr, b_data, e.a, e.d);
                end
            end
        end
        if (f_we) begin
            n_we++;
            n_tests++;
            if (qf.size() == 0) begin
                n_fail++;
                $display("FAIL f_port: unexpected write addr %0d", f_addr);
            end else begin
                e = qf.pop_front();
                if (f_addr !== 10'(e.a) || f_data !== e.d) begin
                    n_fail++;
                    $display("FAIL f_port: got %0d/%h expected %0d/%h",
                             f_addr, f_data, e.a, e.d);
                end
            end
        end
    end

    task automatic m_clear();
        mw = 0; mb = 0; mf = 0;
        m_load = 0; m_run = 0; m_done = 0; m_err = 0;
        m_res = 0; m_perf = 0; m_perf_ok = 1;
    endtask

    task automatic m_stream(input int s, input logic [31:0] d);
        if (!m_load) begin
            m_err = 1;
            return;
        end
        case (s)
            0: if (mw < NW) begin qw.push_back('{mw, d}); mw++; end
               else m_err = 1;
            1: if (mb < NB) begin qb.push_back('{mb, d}); mb++; end
               else m_err = 1;
            default: if (mf < NF) begin qf.push_back('{mf, d}); mf++; end
               else m_err = 1;
        endcase
        if (mw == NW && mb == NB && mf == NF) begin
            m_load = 0;
            m_run = 1;
            m_starts++;
            m_start_cyc = cyc + 2;
        end
    endtask

    task automatic m_apply(input logic v, input logic [4:0] a,
                           input logic [31:0] d, input logic dn,
                           input logic [3:0] r);
        bit was_run;
        bit killed;
        was_run = m_run;
        killed = 0;
        if (v) begin
            if (a == 5'h1C) begin
                if (d[0]) begin
                    m_clear();
                    killed = 1;
                end
            end else if (a == 5'h00) begin
                if (d[0]) begin
                    if (!m_load && !m_run && !m_done) m_load = 1;
                end else begin
                    if (m_run) m_perf_ok = 0;
                    killed = 1;
                    m_load = 0; m_run = 0; m_done = 0;
                    mw = 0; mb = 0; mf = 0;
                end
            end else if (a == 5'h04) m_stream(0, d);
            else if (a == 5'h08) m_stream(1, d);
            else if (a == 5'h0C) m_stream(2, d);
        end
        if (dn && was_run && !killed) begin
            m_run = 0;
            m_done = 1;
            m_res = {28'd0, r};
            m_perf = cyc - m_start_cyc;
            m_perf_ok = 1;
        end
    endtask

    // called at posedge+1; the DUT samples at the next posedge
    task automatic drive(input logic v, input logic [4:0] a,
                         input logic [31:0] d, input logic dn,
                         input logic [3:0] r);
        reg_wr_valid = v;
        reg_wr_addr = a;
        reg_wr_data = d;
        core_done = dn;
        core_result = r;
        m_apply(v, a, d, dn, r);
        @(posedge clk);
        #1;
        reg_wr_valid = 1'b0;
        core_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 5'h00, 0, 0, 0);
    endtask

    task automatic check_model(input string tag);
        @(negedge clk);
        chk({tag, ".done"}, status_done, m_done);
        chk({tag, ".res"}, result_out, m_res);
        chk({tag, ".err"}, err_sticky, m_err);
        if (m_perf_ok) chk({tag, ".perf"}, perf_cycles, m_perf);
        chk({tag, ".starts"}, n_starts, m_starts);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".flags"},
            {w_we, b_we, f_we, core_start, status_done, err_sticky}, 0);
        chk({tag, ".addr"}, {w_addr, b_addr, f_addr}, 0);
        chk({tag, ".w_data"}, w_data, 0);
        chk({tag, ".b_data"}, b_data, 0);
        chk({tag, ".f_data"}, f_data, 0);
        chk({tag, ".result"}, result_out, 0);
        chk({tag, ".perf"}, perf_cycles, 0);
    endtask

    task automatic load_all();
        for (int i = 0; i < NW; i++) drive(1, 5'h04, $urandom, 0, 0);
        for (int i = 0; i < NB; i++) drive(1, 5'h08, $urandom, 0, 0);
        for (int i = 0; i < NF; i++) drive(1, 5'h0C, $urandom, 0, 0);
    endtask

    task automatic wait_start(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (core_start) seen = 1;
        end
        chk({tag, ".start_seen"}, seen, 1);
        if (seen) chk({tag, ".start_cyc"}, cyc, m_start_cyc);
    endtask

    task automatic run_core(input string tag, input int lat,
                            input logic [3:0] res);
        wait_start(tag);
        repeat (lat) @(posedge clk);
        #1;
        drive(0, 5'h00, 0, 1, res);
        check_model(tag);
    endtask

    typedef struct {
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        err;
        int          we;
    } vec_t;

    localparam int NV = 12;
    vec_t tab[NV];

    initial begin
        int   rem[3];
        logic [4:0] sa[3];
        int   st0;
        int   we0;

        tab[0]  = '{5'h04, 32'h11, 5'h10, 32'h0, 1'b1, 0};
        tab[1]  = '{5'h08, 32'h12, 5'h14, 32'h0, 1'b1, 0};
        tab[2]  = '{5'h0C, 32'h13, 5'h18, 32'h0, 1'b1, 0};
        tab[3]  = '{5'h10, 32'h1, 5'h14, 32'h1, 1'b0, 0};
        tab[4]  = '{5'h18, 32'h1, 5'h1C, 32'h0, 1'b0, 0};
        tab[5]  = '{5'h00, 32'h1, 5'h04, 32'hAB, 1'b0, 1};
        tab[6]  = '{5'h00, 32'h1, 5'h0C, 32'hCD, 1'b0, 1};
        tab[7]  = '{5'h00, 32'h2, 5'h08, 32'h5, 1'b1, 0};
        tab[8]  = '{5'h04, 32'h7, 5'h1C, 32'h1, 1'b0, 0};
        tab[9]  = '{5'h04, 32'h7, 5'h1C, 32'h2, 1'b1, 0};
        tab[10] = '{5'h00, 32'h1, 5'h1C, 32'h1, 1'b0, 0};
        tab[11] = '{5'h02, 32'h1, 5'h04, 32'h9, 1'b1, 0};

        m_clear();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(1, 5'h1C, 1, 0, 0);
            we0 = n_we;
            drive(1, tab[i].a0, tab[i].d0, 0, 0);
            drive(1, tab[i].a1, tab[i].d1, 0, 0);
            idle(1);
            @(negedge clk);
            chk($sformatf("vec%0d.err", i), err_sticky, tab[i].err);
            chk($sformatf("vec%0d.we", i), n_we - we0, tab[i].we);
            @(posedge clk);
            #1;
        end
        drive(1, 5'h1C, 1, 0, 0);
        check_model("vec_end");

        drive(1, 5'h00, 1, 0, 0);
        load_all();
        run_core("full", 50, 4'd7);
        chk("full.perf50", perf_cycles, 50);
        chk("full.res7", result_out, 7);
        drive(1, 5'h00, 1, 0, 0);
        check_model("full.en1_in_done");
        drive(1, 5'h00, 0, 0, 0);
        check_model("full.en0");

        for (int k = 0; k < 10; k++) begin
            drive(1, 5'h00, 1, 0, 0);
            load_all();
            run_core($sformatf("img%0d", k), 5 + 3 * k, 4'(k));
            chk($sformatf("img%0d.result", k), result_out, k);
            drive(1, 5'h00, 0, 0, 0);
            idle(1);
            check_model($sformatf("img%0d.cleared", k));
        end

        sa[0] = 5'h04; sa[1] = 5'h08; sa[2] = 5'h0C;
        rem[0] = NW; rem[1] = NB; rem[2] = NF;
        st0 = n_starts;
        drive(1, 5'h00, 1, 0, 0);
        for (int k = 0; k < NW + NB + NF - 1; k++) begin
            int s;
            do s = $urandom_range(2); while (rem[s] == 0);
            rem[s]--;
            drive(1, sa[s], $urandom, 0, 0);
            if ($urandom_range(15) == 0) idle(1);
        end
        idle(6);
        chk("ilv.no_early_start", n_starts, st0);
        for (int s = 0; s < 3; s++) begin
            if (rem[s] != 0) drive(1, sa[s], $urandom, 0, 0);
        end
        run_core("ilv", 33, 4'd6);
        drive(1, 5'h00, 0, 0, 0);

        drive(1, 5'h00, 1, 0, 0);
        load_all();
        wait_start("abort");
        @(posedge clk);
        #1;
        idle(3);
        drive(1, 5'h00, 0, 0, 0);
        idle(3);
        drive(0, 5'h00, 0, 1, 4'hC);
        check_model("abort");
        chk("abort.res_kept", result_out, 6);

        drive(1, 5'h00, 1, 0, 0);
        for (int i = 0; i < NB + 1; i++) drive(1, 5'h08, $urandom, 0, 0);
        drive(1, 5'h00, 0, 0, 0);
        drive(1, 5'h08, 32'hDEAD, 0, 0);
        idle(1);
        check_model("ovf");
        chk("ovf.err", err_sticky, 1);
        drive(1, 5'h1C, 1, 0, 0);
        check_model("ovf.clr");
        drive(1, 5'h0C, 32'hBEEF, 0, 0);
        check_model("idle_strm");
        chk("idle_strm.err", err_sticky, 1);
        drive(1, 5'h1C, 1, 0, 0);

        drive(1, 5'h00, 1, 0, 0);
        load_all();
        run_core("pre_race", 9, 4'd9);
        drive(1, 5'h00, 0, 0, 0);
        drive(1, 5'h00, 1, 0, 0);
        load_all();
        wait_start("race");
        @(posedge clk);
        #1;
        idle(4);
        drive(1, 5'h1C, 1, 1, 4'd5);
        check_model("race");
        chk("race.res", result_out, 0);

        drive(1, 5'h00, 1, 0, 0);
        for (int i = 0; i < 400; i++) drive(1, 5'h0C, $urandom, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("arst");
        m_clear();
        qw.delete();
        qb.delete();
        qf.delete();
        st0 = n_starts;
        repeat (3) @(negedge clk);
        chk("arst.no_start", n_starts, st0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 5'h00, 1, 0, 0);
        load_all();
        run_core("reload", 20, 4'd3);
        drive(1, 5'h00, 0, 0, 0);

        for (int c = 0; c < 400; c++) begin
            int r;
            logic [4:0] a;
            logic [31:0] d;
            r = $urandom_range(63);
            d = $urandom;
            if (r < 2) a = 5'h1C;
            else if (r < 6) begin a = 5'h00; d = {31'd0, d[0]}; end
            else if (r < 10) a = 5'h10 + 5'(4 * (r - 6) % 12);
            else a = sa[r % 3];
            drive($urandom_range(3) != 0, a, d,
                  $urandom_range(49) == 0, 4'($urandom));
            if (c % 50 == 49) check_model($sformatf("soak%0d", c));
        end
        idle(2);
        check_model("soak_end");

        chk("q_empty", qw.size() + qb.size() + qf.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
